branch_resolve_ctrl: RTL
========================

Name: branch_resolve_ctrl

Overview:
- Decode-stage controller that sequences the branch condition comparator in the 5-stage MIPS pipeline.
- Selects operands for the comparator: regfile, MEM-stage forward, or stall.
- Holds IF/ID while a source operand is unavailable.
- Resolves the branch, producing taken / target / link-write signals. The architectural delay slot is preserved, so there is no flush on taken.

Parameters:
- ADDR_W, 32, PC/address width.
- MAX_WAIT, 4, stall-cycle bound; exceeding it raises wait_err.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  exception/eret flush; aborts any pending branch.
- id_valid  in  1  ID holds a valid instruction.
- id_op  in  6  opcode.
- id_rs  in  5  rs field.
- id_rt  in  5  rt field (also REGIMM subcode).
- id_imm  in  16  branch offset.
- id_pc  in  ADDR_W  PC of the branch.
- rf_rs_data  in  32  regfile read port A.
- rf_rt_data  in  32  regfile read port B.
- ex_regwrite  in  1  EX instruction writes the regfile.
- ex_wreg  in  5  EX destination register.
- mem_regwrite  in  1  MEM instruction writes the regfile.
- mem_memtoreg  in  1  MEM instruction is a load.
- mem_wreg  in  5  MEM destination register.
- mem_aluout  in  32  MEM ALU result.
- stall_f  out  1  hold PC.
- stall_d  out  1  hold IF/ID.
- branch_taken  out  1  select branch target this cycle.
- pc_branch  out  ADDR_W  id_pc + 4 + (sext(id_imm) << 2).
- link_we  out  1  BGEZAL/BLTZAL: write $31.
- link_data  out  ADDR_W  id_pc + 8.
- wait_err  out  1  sticky: stall exceeded MAX_WAIT.

Behaviour:
- Branch decode: is_br = id_valid & (op ∈ {BEQ 000100, BNE 000101, BLEZ 000110, BGTZ 000111} | (op==REGIMM 000001 & rt ∈ {BLTZ 00000, BGEZ 00001, BLTZAL 10000, BGEZAL 10001})). Any other REGIMM rt is not a branch.
- Operand need: rs for all branches; rt only for BEQ/BNE.
- A register is never a hazard or forward source if it is $0.
- Hazard per needed register r:
  - (ex_regwrite & ex_wreg==r): stall, because an EX result is not forwarded to ID.
  - (mem_regwrite & mem_memtoreg & mem_wreg==r): stall.
  - Else if (mem_regwrite & mem_wreg==r): operand = mem_aluout.
  - Else: operand = regfile data.
- FSM states and transitions:
  - IDLE:
    - is_br & hazard → WAIT, with stall_f = stall_d = 1 and wait_cnt = 1.
    - is_br & !hazard → resolve this cycle; stay in IDLE.
  - WAIT:
    - stall outputs are 1 while hazard persists; wait_cnt increments and saturates at MAX_WAIT+1.
    - wait_cnt > MAX_WAIT sets wait_err, which is sticky until rst.
    - Hazard clears → resolve this cycle, stall = 0, → IDLE, wait_cnt = 0.
  - flush in any state → IDLE, wait_cnt = 0, all combinational outputs forced 0 that cycle. flush has priority over resolve.
- Resolve cycle outputs:
  - branch_taken = condition result, where:
    - BEQ: a==b.
    - BNE: a!=b.
    - BGEZ/BGEZAL: !a[31].
    - BLTZ/BLTZAL: a[31].
    - BGTZ: signed a>0.
    - BLEZ: signed a<=0.
  - link_we = 1 for BGEZAL/BLTZAL regardless of taken.
  - Outputs are 0 whenever no resolve happens, including during stall cycles.
- pc_branch and link_data are pure functions of id_pc/id_imm and are always driven; they are 32-bit wrap-around adds.
- Latency: 0 cycles with no hazard; 1 cycle per stall otherwise. Resolution is always in the cycle where stall_d falls.
- Reset: state = IDLE, wait_cnt = 0, wait_err = 0, stall_f = stall_d = branch_taken = link_we = 0.
- A branch in the delay slot of a stalled branch cannot occur, because ID is held.

Optional Feature:
- Macro BRANCH_STATS_EN.
- When defined, adds outputs stat_branches [31:0], stat_taken [31:0], stat_stall_cycles [31:0]:
  - Each counter increments by 1 per resolve, per taken resolve, and per stall cycle respectively.
  - All counters wrap, and are reset by rst (not by flush).
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package (defines) holds OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BRANCHS, OP_BLTZ, OP_BGEZ, OP_BLTZAL, OP_BGEZAL, and the FSM state encodings S_IDLE / S_WAIT.
- One sub-module, branch_cond: a combinational condition evaluator (a, b, op, rt → taken).
- The hazard/forwarding mux and FSM stay in the top module.

Test Plan:
- BEQ rs=$2=5, rt=$3=5, no hazards, id_pc=0x100, imm=0x0004 → same cycle branch_taken=1, pc_branch=0x114, stall_d=0.
- BNE with ex_regwrite=1, ex_wreg=$2 = rs, for 1 cycle; next cycle mem_aluout=7 forwarded, rt=7 → 1 stall cycle, then resolve branch_taken=0.
- BGEZAL rs=$4=0xFFFFFFFF, id_pc=0x200 → branch_taken=0, link_we=1, link_data=0x208.
- Load-use: mem_memtoreg=1, mem_wreg=$5, BLTZ rs=$5 held for 6 cycles → stall for 6 cycles, wait_err rises once wait_cnt>4, resolve on cycle 7.
- flush asserted in WAIT → next cycle state IDLE, stall=0, branch_taken=0; rst mid-WAIT → all outputs 0 the next cycle.
- Branch on $0 with ex_wreg=$0, ex_regwrite=1 → no stall; BLEZ $0 taken=1.

Source files
------------

// File: rtl/branch_resolve_ctrl_pkg.sv
// branch_resolve_ctrl_pkg: branch opcodes, REGIMM subcodes, FSM states and branch decode
package branch_resolve_ctrl_pkg;
  localparam logic [5:0] OP_BRANCHS = 6'b000001;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [4:0] OP_BLTZ    = 5'b00000;
  localparam logic [4:0] OP_BGEZ    = 5'b00001;
  localparam logic [4:0] OP_BLTZAL  = 5'b10000;
  localparam logic [4:0] OP_BGEZAL  = 5'b10001;
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  function automatic logic is_branch(input logic [5:0] op, input logic [4:0] rt);
    return (op inside {OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ}) ||
           (op == OP_BRANCHS && (rt inside {OP_BLTZ, OP_BGEZ, OP_BLTZAL, OP_BGEZAL}));
  endfunction
endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// branch_resolve_ctrl_if: ID-stage, forwarding and resolve signals of the branch controller
interface branch_resolve_ctrl_if #(parameter int ADDR_W = 32);
  logic              flush, id_valid;
  logic [5:0]        id_op;
  logic [4:0]        id_rs, id_rt;
  logic [15:0]       id_imm;
  logic [ADDR_W-1:0] id_pc;
  logic [31:0]       rf_rs_data, rf_rt_data;
  logic              ex_regwrite;
  logic [4:0]        ex_wreg;
  logic              mem_regwrite, mem_memtoreg;
  logic [4:0]        mem_wreg;
  logic [31:0]       mem_aluout;
  logic              stall_f, stall_d, branch_taken, link_we, wait_err;
  logic [ADDR_W-1:0] pc_branch, link_data;
  modport master (
    output flush, id_valid, id_op, id_rs, id_rt, id_imm, id_pc, rf_rs_data, rf_rt_data,
           ex_regwrite, ex_wreg, mem_regwrite, mem_memtoreg, mem_wreg, mem_aluout,
    input  stall_f, stall_d, branch_taken, pc_branch, link_we, link_data, wait_err
  );
  modport slave (
    input  flush, id_valid, id_op, id_rs, id_rt, id_imm, id_pc, rf_rs_data, rf_rt_data,
           ex_regwrite, ex_wreg, mem_regwrite, mem_memtoreg, mem_wreg, mem_aluout,
    output stall_f, stall_d, branch_taken, pc_branch, link_we, link_data, wait_err
  );
endinterface

// File: rtl/branch_resolve_ctrl_branch_cond.sv
// branch_cond: combinational MIPS branch condition evaluator
module branch_cond
  import branch_resolve_ctrl_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [5:0]  op,
  input  logic [4:0]  rt,
  output logic        taken
);
  always_comb
    taken = op == OP_BEQ     ? a == b :
            op == OP_BNE     ? a != b :
            op == OP_BLEZ    ? a[31] | ~|a :
            op == OP_BGTZ    ? ~a[31] & |a :
            op == OP_BRANCHS ? (rt inside {OP_BGEZ, OP_BGEZAL}) ^ a[31] :
            1'b0;
endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: ID-stage branch operand select, hazard stall FSM and resolve.
// Optional BRANCH_STATS_EN adds resolve/taken/stall-cycle counters.
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  branch_resolve_ctrl_if.slave bus
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_taken,
  output logic [31:0] stat_stall_cycles
`endif
);
  localparam int CW = $clog2(MAX_WAIT + 2);
  localparam logic [CW-1:0] SAT = CW'(MAX_WAIT + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0] a, b;
  logic is_br, need_rt, haz_rs, haz_rt, fwd_rs, fwd_rt, hazard, stall, resolve, cond, taken, wait_err;
  assign is_br   = bus.id_valid & is_branch(bus.id_op, bus.id_rt);
  assign need_rt = bus.id_op inside {OP_BEQ, OP_BNE};
  // $0 can never be produced by an in-flight instruction
  assign haz_rs = |bus.id_rs & ((bus.ex_regwrite & bus.ex_wreg == bus.id_rs) |
                  (bus.mem_regwrite & bus.mem_memtoreg & bus.mem_wreg == bus.id_rs));
  assign haz_rt = |bus.id_rt & ((bus.ex_regwrite & bus.ex_wreg == bus.id_rt) |
                  (bus.mem_regwrite & bus.mem_memtoreg & bus.mem_wreg == bus.id_rt));
  assign fwd_rs = |bus.id_rs & bus.mem_regwrite & bus.mem_wreg == bus.id_rs;
  assign fwd_rt = |bus.id_rt & bus.mem_regwrite & bus.mem_wreg == bus.id_rt;
  assign a = fwd_rs ? bus.mem_aluout : bus.rf_rs_data;
  assign b = fwd_rt ? bus.mem_aluout : bus.rf_rt_data;
  assign hazard = is_br & (haz_rs | (need_rt & haz_rt));
  branch_cond u_cond (.a(a), .b(b), .op(bus.id_op), .rt(bus.id_rt), .taken(cond));
  always_comb begin
    stall   = ~bus.flush & hazard;
    resolve = ~bus.flush & is_br & ~hazard;
    state_n = stall ? S_WAIT : S_IDLE;
    cnt_n   = ~stall ? '0 : state == S_IDLE ? CW'(1) : cnt == SAT ? cnt : cnt + CW'(1);
  end
  always_ff @(posedge clk)
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      wait_err <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      wait_err <= wait_err | (cnt_n > CW'(MAX_WAIT));
    end
  assign taken            = resolve & cond;
  assign bus.stall_f      = stall;
  assign bus.stall_d      = stall;
  assign bus.branch_taken = taken;
  assign bus.link_we      = resolve & bus.id_op == OP_BRANCHS & bus.id_rt[4];
  assign bus.pc_branch    = bus.id_pc + ADDR_W'(4) + {{(ADDR_W-18){bus.id_imm[15]}}, bus.id_imm, 2'b00};
  assign bus.link_data    = bus.id_pc + ADDR_W'(8);
  assign bus.wait_err     = wait_err;
`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk)
    if (rst) begin
      stat_branches     <= '0;
      stat_taken        <= '0;
      stat_stall_cycles <= '0;
    end else begin
      stat_branches     <= stat_branches + 32'(resolve);
      stat_taken        <= stat_taken + 32'(taken);
      stat_stall_cycles <= stat_stall_cycles + 32'(stall);
    end
`endif
endmodule
